debounce_event: RTL and testbench

DEBOUNCE_EVENT -- requirements
Module: debounce_event

---
 rtl/debounce_event.sv | 159 +++++++++++++++
 tb/tb_debounce_event.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_event.sv
// Per-channel synchroniser, debouncer and press/release/long-press event generator.
// Long-press logic is built only when DEBOUNCE_EVENT_LONGPRESS_EN is defined.
module debounce_event #(
  parameter int    WIDTH         = 2,
  parameter string POLARITY      = "LOW",
  parameter int    TIMEOUT       = 50000,
  parameter int    TIMEOUT_WIDTH = 16,
  parameter int    LONG_TIMEOUT  = 50000000,
  parameter int    LONG_WIDTH    = 26
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic [WIDTH-1:0] long_pulse,
  output logic [WIDTH-1:0] long_held
);

  localparam logic INACT = (POLARITY == "HIGH") ? 1'b0 : 1'b1;

  localparam logic [1:0] REL    = 2'd0;
  localparam logic [1:0] WAIT_P = 2'd1;
  localparam logic [1:0] HELD   = 2'd2;
  localparam logic [1:0] WAIT_R = 2'd3;

  // Entry cycle counts as the first stable cycle, so fire one short of TIMEOUT-1.
  localparam logic [TIMEOUT_WIDTH-1:0] T_LAST =
    TIMEOUT_WIDTH'(TIMEOUT - 2);
  localparam logic [TIMEOUT_WIDTH-1:0] T_ONE =
    TIMEOUT_WIDTH'(1);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be 1..32");
  end
  if (POLARITY != "LOW" && POLARITY != "HIGH") begin : g_bad_pol
    $error("POLARITY must be LOW or HIGH");
  end
  if (TIMEOUT < 2 ||
      longint'(TIMEOUT) >= (longint'(1) << TIMEOUT_WIDTH)) begin : g_bad_to
    $error("TIMEOUT out of range for TIMEOUT_WIDTH");
  end
  if (LONG_TIMEOUT < 2 ||
      longint'(LONG_TIMEOUT) >= (longint'(1) << LONG_WIDTH)) begin : g_bad_lto
    $error("LONG_TIMEOUT out of range for LONG_WIDTH");
  end

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= {WIDTH{INACT}};
      sync <= {WIDTH{INACT}};
    end else begin
      meta <= data_in;
      sync <= meta;
    end
  end

`ifdef DEBOUNCE_EVENT_LONGPRESS_EN
  localparam logic [LONG_WIDTH-1:0] L_LAST =
    LONG_WIDTH'(LONG_TIMEOUT - 1);
  localparam logic [LONG_WIDTH-1:0] L_TOP =
    LONG_WIDTH'(LONG_TIMEOUT);
  localparam logic [LONG_WIDTH-1:0] L_ONE =
    LONG_WIDTH'(1);
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic [1:0]               st;
    logic [TIMEOUT_WIDTH-1:0] cnt;
    logic                     dout;
    logic                     pp;
    logic                     rp;
    logic                     moved;
    logic                     done;
    logic                     fire_p;
    logic                     fire_r;

    assign moved  = sync[i] ^ dout;
    assign done   = moved && (cnt == T_LAST);
    assign fire_p = done && (st == WAIT_P);
    assign fire_r = done && (st == WAIT_R);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st   <= REL;
        cnt  <= '0;
        dout <= INACT;
        pp   <= 1'b0;
        rp   <= 1'b0;
      end else begin
        pp <= fire_p;
        rp <= fire_r;
        unique case (st)
          REL, HELD: begin
            if (moved) begin
              st  <= (st == REL) ? WAIT_P : WAIT_R;
              cnt <= '0;
            end
          end
          default: begin
            if (!moved) begin
              st <= (st == WAIT_P) ? REL : HELD;
            end else if (done) begin
              st   <= (st == WAIT_P) ? HELD : REL;
              dout <= sync[i];
            end else begin
              cnt <= cnt + T_ONE;
            end
          end
        endcase
      end
    end

    assign data_out[i]      = dout;
    assign press_pulse[i]   = pp;
    assign release_pulse[i] = rp;

`ifdef DEBOUNCE_EVENT_LONGPRESS_EN
    logic [LONG_WIDTH-1:0] lcnt;
    logic                  lp;
    logic                  lh;
    logic                  active;

    assign active = (st == HELD) || (st == WAIT_R);

    // A release on the same edge as the long threshold suppresses the pulse.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lcnt <= '0;
        lp   <= 1'b0;
        lh   <= 1'b0;
      end else begin
        lp <= 1'b0;
        if (fire_p || fire_r) begin
          lcnt <= '0;
          lh   <= 1'b0;
        end else if (active && lcnt != L_TOP) begin
          lcnt <= lcnt + L_ONE;
          if (lcnt == L_LAST) begin
            lp <= 1'b1;
            lh <= 1'b1;
          end
        end
      end
    end

    assign long_pulse[i] = lp;
    assign long_held[i]  = lh;
`else
    assign long_pulse[i] = 1'b0;
    assign long_held[i]  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_debounce_event.sv
// Directed bench for debounce_event with a cycle-level behavioural model.
// WIDTH=2, active-low, TIMEOUT=8, LONG_TIMEOUT=40.
module tb_debounce_event;

  localparam int T  = 8;
  localparam int LT = 40;
`ifdef DEBOUNCE_EVENT_LONGPRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] data_in;
  logic [1:0] data_out;
  logic [1:0] press_pulse;
  logic [1:0] release_pulse;
  logic [1:0] long_pulse;
  logic [1:0] long_held;

  debounce_event #(
    .WIDTH(2),
    .POLARITY("LOW"),
    .TIMEOUT(T),
    .TIMEOUT_WIDTH(4),
    .LONG_TIMEOUT(LT),
    .LONG_WIDTH(6)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .data_out(data_out),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .long_pulse(long_pulse),
    .long_held(long_held)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, a, e);
    end
  endtask

  // Model: an input level seen by the debouncer lags data_in by two edges;
  // data_out follows once that level has differed for T consecutive edges.
  logic [1:0] m_out = 2'b11;
  logic [1:0] m_pp  = 2'b00;
  logic [1:0] m_rp  = 2'b00;
  logic [1:0] m_lp  = 2'b00;
  logic [1:0] m_lh  = 2'b00;
  int         run [2] = '{0, 0};
  int         hc  [2] = '{0, 0};
  logic [1:0] hq [$];

  initial begin
    logic [1:0] s;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        hq.delete();
        m_out = 2'b11;
        m_pp  = 2'b00;
        m_rp  = 2'b00;
        m_lp  = 2'b00;
        m_lh  = 2'b00;
        run   = '{0, 0};
        hc    = '{0, 0};
      end else begin
        hq.push_back(data_in);
        s = (hq.size() > 2) ? hq.pop_front() : 2'b11;
        for (int i = 0; i < 2; i++) begin
          m_pp[i] = 1'b0;
          m_rp[i] = 1'b0;
          m_lp[i] = 1'b0;
          run[i]  = (s[i] != m_out[i]) ? run[i] + 1 : 0;
          if (run[i] == T) begin
            m_out[i] = s[i];
            run[i]   = 0;
            if (s[i] == 1'b0) begin
              m_pp[i] = 1'b1;
              hc[i]   = 0;
            end else begin
              m_rp[i] = 1'b1;
              m_lh[i] = 1'b0;
            end
          end else if (LONG_EN && m_out[i] == 1'b0) begin
            hc[i]++;
            if (hc[i] == LT) begin
              m_lp[i] = 1'b1;
              m_lh[i] = 1'b1;
            end
          end
        end
      end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int pc [2]    = '{0, 0};
  int rc [2]    = '{0, 0};
  int lc0       = 0;
  int p0_cyc    = 0;
  int l0_cyc    = 0;
  int both_seen = 0;

  always @(negedge clk) begin
    chk("data_out", data_out, m_out);
    chk("press_pulse", press_pulse, m_pp);
    chk("release_pulse", release_pulse, m_rp);
    chk("long_pulse", long_pulse, m_lp);
    chk("long_held", long_held, m_lh);
    if (reset_n) begin
      for (int i = 0; i < 2; i++) begin
        if (press_pulse[i]) pc[i]++;
        if (release_pulse[i]) rc[i]++;
      end
      if (press_pulse[0]) p0_cyc = cyc;
      if (long_pulse[0]) begin
        lc0++;
        l0_cyc = cyc;
      end
      if (press_pulse == 2'b11) both_seen++;
    end
  end

  task automatic measure(input int ch, input logic lvl, output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (data_out[ch] !== lvl && n < 30);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  int n;
  int gap;

  initial begin
    reset_n = 1'b0;
    data_in = 2'b11;
    repeat (3) @(negedge clk);
    chk("reset_out", data_out, 2'b11);
    chk("reset_events",
        {press_pulse, release_pulse, long_pulse, long_held}, 0);
    reset_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_out", data_out, 2'b11);
    chk("idle_events", pc[0] + pc[1] + rc[0] + rc[1], 0);

    // ch0 clean press: latency and pulse placement
    data_in = 2'b10;
    measure(0, 1'b0, n);
    chk("press_latency", n, T + 2);
    chk("press_now", press_pulse[0], 1);
    @(posedge clk);
    #1;
    chk("press_gone", press_pulse[0], 0);
    @(negedge clk);
    repeat (49) @(negedge clk);
    chk("long_held_on", long_held[0], LONG_EN);
    chk("long_count", lc0, LONG_EN ? 1 : 0);
    gap = (lc0 > 0) ? l0_cyc - p0_cyc : 0;
    chk("long_gap", gap, LONG_EN ? LT : 0);
    data_in = 2'b11;
    repeat (20) @(negedge clk);
    chk("ch0_release", rc[0], 1);
    chk("long_held_off", long_held[0], 0);

    // ch1: 7-cycle glitch ignored, 8-cycle press accepted
    data_in = 2'b01;
    repeat (7) @(negedge clk);
    data_in = 2'b11;
    repeat (20) @(negedge clk);
    chk("glitch7_press", pc[1], 0);
    chk("glitch7_out", data_out, 2'b11);
    data_in = 2'b01;
    repeat (8) @(negedge clk);
    data_in = 2'b11;
    repeat (20) @(negedge clk);
    chk("press8_press", pc[1], 1);
    chk("press8_release", rc[1], 1);

    // simultaneous press, bouncy release
    data_in = 2'b00;
    repeat (20) @(negedge clk);
    chk("both_same_cycle", both_seen, 1);
    data_in = 2'b11;
    repeat (3) @(negedge clk);
    data_in = 2'b00;
    repeat (3) @(negedge clk);
    data_in = 2'b11;
    repeat (25) @(negedge clk);
    chk("bounce_rel0", rc[0], 2);
    chk("bounce_rel1", rc[1], 2);
    chk("bounce_out", data_out, 2'b11);

    // reset while ch0 counts (count 5) and ch1 is held
    data_in = 2'b01;
    repeat (20) @(negedge clk);
    chk("ch1_held", data_out, 2'b01);
    data_in = 2'b00;
    repeat (8) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out", data_out, 2'b11);
    chk("async_rst_evt",
        {press_pulse, release_pulse, long_pulse, long_held}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    measure(0, 1'b0, n);
    chk("post_rst_latency", n, T + 2);
    chk("post_rst_press", press_pulse, 2'b11);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
